// File: rtl/i2c_pkg.sv
// Shared I2C definitions for i2c_slave, i2c_master and i2c_slave_regctl.
//   regctl_state_t : register-controller protocol state
//   I2C_BYTE_W     : width of one I2C data byte
package i2c_pkg;

  localparam int I2C_BYTE_W = 8;

  typedef enum logic [1:0] {
    RC_IDLE,
    RC_PTR,
    RC_DATA
  } regctl_state_t;

endpackage

// File: rtl/i2c_slave_regctl.sv
// Register-access controller behind the i2c_slave byte interface.
// The first byte after START loads the register pointer; following bytes
// write regs[ptr] with auto-increment. Reads stream regs[ptr] out through
// data_i with auto-increment on every consumed byte. A local host can write
// any register, and all registers are visible in parallel on reg_q.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   bus_start, bus_stop        1-cycle START/repeated-START and STOP pulses
//   data_o, data_o_valid       byte written by the I2C master
//   data_i, data_i_valid       byte returned on I2C reads (= regs[ptr])
//   data_i_ready               slave consumed data_i
//   hw_we, hw_addr, hw_wdata   host write port
//   hw_busy                    host write this cycle dropped (I2C has priority)
//   reg_q                      all registers flattened, reg k at [8k+7:8k]
//   wr_evt, wr_evt_addr        pulse + address of a committed I2C write
//   ptr_o                      current pointer
//   err_wr_idle                sticky: data byte arrived outside a transaction
module i2c_slave_regctl
  import i2c_pkg::*;
#(
  parameter int                  NUM_REGS = 8,
  parameter int                  ADDR_W   = $clog2(NUM_REGS),
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             bus_start,
  input  logic                             bus_stop,
  input  logic [I2C_BYTE_W-1:0]            data_o,
  input  logic                             data_o_valid,
  output logic [I2C_BYTE_W-1:0]            data_i,
  output logic                             data_i_valid,
  input  logic                             data_i_ready,
  input  logic                             hw_we,
  input  logic [ADDR_W-1:0]                hw_addr,
  input  logic [I2C_BYTE_W-1:0]            hw_wdata,
  output logic                             hw_busy,
  output logic [NUM_REGS*I2C_BYTE_W-1:0]   reg_q,
  output logic                             wr_evt,
  output logic [ADDR_W-1:0]                wr_evt_addr,
  output logic [ADDR_W-1:0]                ptr_o,
  output logic                             err_wr_idle
);

  regctl_state_t           state, state_nxt;
  logic [I2C_BYTE_W-1:0]   regs [NUM_REGS];
  logic [ADDR_W-1:0]       ptr;

  logic i2c_wr, i2c_commit, ptr_load, rd_adv;

  assign i2c_wr     = (state == RC_DATA) && data_o_valid;
  // Read-only registers still consume the byte and advance the pointer.
  assign i2c_commit = i2c_wr && !RO_MASK[ptr];
  assign ptr_load   = (state == RC_PTR) && data_o_valid;
  // A ready pulse only counts while a byte is actually on offer.
  assign rd_adv     = data_i_ready && data_i_valid;
  assign hw_busy    = hw_we && i2c_commit;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RC_IDLE;
    else        state <= state_nxt;
  end

  // Next state: START beats STOP, both override byte-driven progress.
  always_comb begin
    state_nxt = state;
    if (state == RC_PTR && data_o_valid) state_nxt = RC_DATA;
    if (bus_stop)                        state_nxt = RC_IDLE;
    if (bus_start)                       state_nxt = RC_PTR;
  end

  // Pointer: a write and a read refill in the same cycle advance it once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 ptr <= '0;
    else if (ptr_load)          ptr <= data_o[ADDR_W-1:0];
    else if (i2c_wr || rd_adv)  ptr <= ptr + ADDR_W'(1);
  end

  // Register file: I2C write wins over the host port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_REGS; k++) regs[k] <= '0;
    end else if (i2c_commit) begin
      regs[ptr] <= data_o;
    end else if (hw_we) begin
      regs[hw_addr] <= hw_wdata;
    end
  end

  // Read path and status flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_i       <= '0;
      data_i_valid <= 1'b0;
      wr_evt       <= 1'b0;
      wr_evt_addr  <= '0;
      err_wr_idle  <= 1'b0;
    end else begin
      // Tracks regs[ptr] every cycle, so writes to the current byte show up
      // one cycle later; the one-cycle valid drop covers the pointer move.
      data_i       <= regs[ptr];
      data_i_valid <= !rd_adv;
      wr_evt       <= i2c_commit;
      if (i2c_commit) wr_evt_addr <= ptr;
      if (state == RC_IDLE && data_o_valid) err_wr_idle <= 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS; k++) reg_q[k*I2C_BYTE_W +: I2C_BYTE_W] = regs[k];
  end

  assign ptr_o = ptr;

endmodule

// File: doc/i2c_slave_regctl.md
Name: i2c_slave_regctl

Overview:
- Register-access controller behind i2c_slave's byte interface (data_o/data_o_valid, data_i/data_i_valid/data_i_ready).
- Turns the raw byte stream into a pointer-addressed register file with auto-increment.
- Also gives the local host a write port and a parallel read view of all registers.
- i2c_slave gains two 1-cycle pulse outputs, bus_start and bus_stop (START/repeated START and STOP detected), which this block consumes.

Parameters:
- NUM_REGS, 8: number of 8-bit registers; must be a power of two, range 2..256.
- ADDR_W, $clog2(NUM_REGS): pointer width.
- RO_MASK, '0: NUM_REGS bits; bit k=1 makes reg k read-only from I2C (host may still write it).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous reset, active-low
- bus_start  in  1  pulse: START or repeated START seen by i2c_slave
- bus_stop  in  1  pulse: STOP seen by i2c_slave
- data_o  in  8  byte written by the I2C master
- data_o_valid  in  1  1-cycle qualifier for data_o
- data_i  out  8  byte the slave returns on an I2C read
- data_i_valid  out  1  data_i holds regs[ptr]
- data_i_ready  in  1  1-cycle pulse: slave consumed data_i
- hw_we  in  1  host write strobe
- hw_addr  in  ADDR_W  host write address
- hw_wdata  in  8  host write data
- hw_busy  out  1  host write in this cycle was dropped
- reg_q  out  NUM_REGS*8  all registers, flattened; reg k at bits [8k+7:8k]
- wr_evt  out  1  1-cycle pulse: I2C write committed
- wr_evt_addr  out  ADDR_W  address of the committed I2C write
- ptr_o  out  ADDR_W  current pointer
- err_wr_idle  out  1  sticky flag: data_o_valid arrived while IDLE; cleared only by reset

Behaviour:
- Reset values: all regs, ptr, data_i, wr_evt, wr_evt_addr, hw_busy and err_wr_idle are 0; data_i_valid is 0; state is IDLE.
- data_i_valid rises the first clk edge after rst_n deasserts.
- Reset asserted mid-transaction aborts it immediately; no partial write is committed.
- FSM states: IDLE, PTR, DATA.
  - bus_start in any state -> PTR. This covers repeated START; ptr is kept.
  - PTR & data_o_valid: ptr <= data_o[ADDR_W-1:0] (upper bits ignored, i.e. modulo NUM_REGS) -> DATA. No register write, no wr_evt.
  - DATA & data_o_valid: if RO_MASK[ptr]=0, regs[ptr] <= data_o and wr_evt=1 / wr_evt_addr=ptr on the next cycle. Then ptr <= ptr+1, wrapping NUM_REGS-1 -> 0. Ptr increments even for RO registers.
  - IDLE & data_o_valid: byte dropped, err_wr_idle <= 1.
  - bus_stop in any state -> IDLE.
  - ptr survives STOP, so "write pointer, STOP, START, read" reads from the set pointer.
  - bus_start and bus_stop in the same cycle: bus_start wins -> PTR.
- Read path (independent of FSM state):
  - data_i is registered as regs[ptr].
  - On data_i_ready: ptr <= ptr+1 (wrapping) and data_i_valid <= 0 for exactly one cycle.
  - Next cycle: data_i = regs[new ptr], data_i_valid <= 1. Refill latency is 2 clk from the ready pulse to a valid new byte.
  - data_i_ready while data_i_valid=0 is ignored: no increment.
  - A host or I2C write to regs[ptr] while data_i_valid=1 updates data_i on the next cycle.
- Simultaneous events:
  - data_o_valid and data_i_ready in the same cycle: the write is committed first, ptr advances by 1 only, and a read refill is still performed.
  - I2C write and hw_we in the same cycle, any addresses: I2C wins. The host write is dropped and hw_busy=1 for that cycle (combinational).
  - Otherwise hw_we writes regs[hw_addr] in one cycle; RO_MASK is ignored for the host.
- ptr_o is the registered ptr.
- reg_q is the direct register outputs (no extra latency).

Decomposition:
- i2c_pkg, shared with i2c_slave/i2c_master:
  - typedef enum logic [1:0] {RC_IDLE, RC_PTR, RC_DATA} regctl_state_t
  - localparam I2C_BYTE_W = 8
- No sub-module. The register file is a flat array inside the block; NUM_REGS is small enough that a separate RAM wrapper adds nothing.

Test Plan:
- Write regs: START, bytes 0x02,0x5A,0x33, STOP -> reg2=0x5A, reg3=0x33; wr_evt pulses with addr 2 then 3; ptr_o=4; state IDLE.
- Wrap: NUM_REGS=8, START, bytes 0x0F,0xA5,0x7E, STOP -> ptr=7, reg7=0xA5, reg0=0x7E, ptr_o=1.
- Read with pointer:
  - preload reg4=0xC3, reg5=0xFF via host;
  - START, byte 0x04, repeated START, two data_i_ready pulses;
  - data_i = 0xC3 then 0xFF; data_i_valid low exactly 1 cycle after each pulse; ptr_o=6.
- Read-only register: RO_MASK bit1=1; START, bytes 0x01,0x22,0x44 -> reg1 unchanged, reg2=0x44, single wr_evt (addr 2).
- Collision:
  - hw_we to addr 3 with 0x11 in the same cycle as an I2C data_o_valid writing 0x99 to reg3;
  - reg3=0x99, hw_busy=1 that cycle; host retry next cycle -> reg3=0x11.
- Error and reset:
  - data_o_valid with no START -> err_wr_idle=1, no reg change;
  - rst_n low mid-DATA -> all outputs 0; data_i_valid=1 one cycle after release.
